// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide engine.
// Provides op/state enums and small op-decoding helpers.
package mult_div_unit_pkg;

    localparam int MD_OP_W = 2;

    typedef enum logic [MD_OP_W-1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        MD_ST_IDLE,
        MD_ST_PREP,
        MD_ST_CALC,
        MD_ST_FIX,
        MD_ST_DONE
    } md_state_e;

    function automatic logic op_is_signed(input md_op_e o);
        return ~o[0];
    endfunction

    function automatic logic op_is_div(input md_op_e o);
        return o[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide.
// Ports: div_i selects divide, acc_i/opnd_i/cnt_i in, acc_o/cnt_o next values.
module mult_div_unit_step #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [CNT_W-1:0]   cnt_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // Multiply: acc = {hi, multiplier}; add multiplicand into hi, shift right.
    assign sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    // The difference is below 2^WIDTH whenever it is kept, so WIDTH bits do.
    assign rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    assign ge      = rem_sh >= {1'b0, opnd_i};
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd_i;

    always_comb begin
        acc_o = {sum, acc_i[WIDTH-1:1]};
        if (div_i) begin
            if (ge) acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
            else    acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end
    end

    assign cnt_o = cnt_i + CNT_W'(1);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine; result {hi,lo} valid while done=1.
// Ports: clk, rst(async high), start, flush, op, operand_1/2 -> busy, done,
// result, div_by_zero. Option: MULT_DIV_FAST_MUL_EN = single-cycle multiply.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, res_q, res_d, step_acc;
    logic [CNT_W-1:0]   cnt_q, cnt_d, step_cnt;
    logic               qs_q, qs_d, rs_q, rs_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   mag_a, mag_b, q_lo, r_hi;
    logic               sgn;

    mult_div_unit_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
        .div_i  (op_is_div(op_q)),
        .acc_i  (acc_q),
        .opnd_i (m_q),
        .cnt_i  (cnt_q),
        .acc_o  (step_acc),
        .cnt_o  (step_cnt)
    );

    assign sgn   = op_is_signed(op_q);
    assign mag_a = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    assign q_lo  = qs_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_hi  = rs_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            MD_ST_IDLE, MD_ST_DONE: begin
                state_d = MD_ST_IDLE;
                if (start) begin
                    state_d = MD_ST_PREP;
                    op_d    = md_op_e'(op);
                    a_d     = operand_1;
                    b_d     = operand_2;
                end
            end
            MD_ST_PREP: begin
                m_d     = mag_b;
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                cnt_d   = '0;
                qs_d    = sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rs_d    = sgn & a_q[WIDTH-1];
                state_d = MD_ST_CALC;
`ifdef MULT_DIV_FAST_MUL_EN
                if (!op_is_div(op_q)) begin
                    acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                    state_d = MD_ST_FIX;
                end
`endif
            end
            MD_ST_CALC: begin
                acc_d = step_acc;
                cnt_d = step_cnt;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_ST_FIX;
            end
            MD_ST_FIX: begin
                state_d = MD_ST_DONE;
                dbz_d   = 1'b0;
                if (!op_is_div(op_q)) begin
                    res_d = qs_q ? -acc_q : acc_q;
                end else if (b_q == '0) begin
                    // Divide by zero reports the raw dividend, no sign fix.
                    res_d = {a_q, {WIDTH{1'b1}}};
                    dbz_d = 1'b1;
                end else begin
                    res_d = {r_hi, q_lo};
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase
        if (flush) begin
            state_d = MD_ST_IDLE;
            res_d   = res_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_ST_IDLE;
            op_q    <= MD_OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == MD_ST_PREP) || (state_q == MD_ST_CALC)
                      || (state_q == MD_ST_FIX);
    assign done        = (state_q == MD_ST_DONE);
    assign result      = res_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit (WIDTH=32).
// Reference model uses plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;

`ifdef MULT_DIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        busy, done, div_by_zero;
    logic [63:0] result;

    int total = 0;
    int bad = 0;
    logic [63:0] last_res = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .flush       (flush),
        .op          (op),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                q = sa * sb;
                return {1'b0, q};
            end
            2'b01: begin
                r = {32'h0, a} * {32'h0, b};
                return {1'b0, r};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q  = sa / sb;
                rm = sa % sb;
                return {1'b0, rm[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] o);
        return (o[1] || !FAST) ? 35 : 3;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called in cycle 1 (just after acceptance edge). n = cycle of done.
    task automatic wait_done(output int n, output bit bok);
        bit seen;
        seen = 0;
        n    = 1;
        bok  = 1;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                if (!busy) bok = 0;
                n++;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [64:0] m;
        int n;
        bit bok;
        m = model(o, a, b);
        op = o;
        operand_1 = a;
        operand_2 = b;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        operand_1 = $urandom;
        operand_2 = $urandom;
        op = 2'($urandom);
        wait_done(n, bok);
        chk("latency", 64'(n), 64'(lat(o)));
        chk("result", result, m[63:0]);
        chk("dbz", {63'h0, div_by_zero}, {63'h0, m[64]});
        chk("busy_span", {63'h0, bok}, 64'h1);
        last_res = m[63:0];
        @(posedge clk);
        #1;
        chk("done_pulse", {63'h0, done}, 64'h0);
    endtask

    logic [1:0]  d_op [7] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b11,
                              2'b01, 2'b11};
    logic [31:0] d_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
                              32'h8000_0000, 32'h5, 32'h3, 32'd12};
    logic [31:0] d_b  [7] = '{32'hFFFF_FFFF, 32'h7, 32'h2, 32'hFFFF_FFFF,
                              32'h0, 32'h4, 32'h4};

    initial begin
        int n, cnt;
        bit bok;
        logic [64:0] m;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_result", result, 64'h0);
        chk("rst_dbz", {63'h0, div_by_zero}, 64'h0);
        rst = 0;
        @(posedge clk);
        #1;

        // Spot values worked out by hand.
        m = model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("hand_multu", m[63:0], 64'hFFFF_FFFE_0000_0001);
        m = model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("hand_ovf", m[63:0], 64'h0000_0000_8000_0000);

        for (int i = 0; i < 7; i++) run_op(d_op[i], d_a[i], d_b[i]);

        for (int i = 0; i < 60; i++) run_op(2'($urandom), pick(), pick());

        // Flush mid-divide: no done, result unchanged.
        run_op(2'b01, 32'd9, 32'd7);
        op = 2'b11;
        operand_1 = 32'd1000;
        operand_2 = 32'd3;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        chk("flush_busy", {63'h0, busy}, 64'h0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("flush_nodone", 64'(cnt), 64'h0);
        chk("flush_result", result, last_res);

        // flush beats start in the same cycle.
        @(posedge clk);
        #1;
        start = 1;
        flush = 1;
        @(posedge clk);
        #1;
        start = 0;
        flush = 0;
        chk("flush_vs_start", {63'h0, busy}, 64'h0);

        // start held high while busy, re-accepted in the DONE cycle.
        op = 2'b01;
        operand_1 = 32'd11;
        operand_2 = 32'd13;
        start = 1;
        @(posedge clk);
        #1;
        op = 2'b11;
        operand_1 = 32'd100;
        operand_2 = 32'd7;
        wait_done(n, bok);
        chk("held_lat", 64'(n), 64'(lat(2'b01)));
        chk("held_res", result, 64'd143);
        @(posedge clk);
        #1;
        start = 0;
        operand_1 = $urandom;
        operand_2 = $urandom;
        wait_done(n, bok);
        chk("b2b_lat", 64'(n), 64'd35);
        chk("b2b_busy", {63'h0, bok}, 64'h1);
        chk("b2b_res", result, {32'd2, 32'd14});
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC.
        op = 2'b10;
        operand_1 = 32'hFFFF_FF00;
        operand_2 = 32'd5;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'h0);
        chk("arst_done", {63'h0, done}, 64'h0);
        chk("arst_result", result, 64'h0);
        chk("arst_dbz", {63'h0, div_by_zero}, 64'h0);
        #2;
        rst = 0;
        @(posedge clk);
        #1;
        run_op(2'b01, 32'd3, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
